// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a shared memory port: a fetch (instruction) bus and
// a memory-stage (data) bus compete for one memory port. Data wins by
// default. A small counter stops a stream of data requests from starving a
// waiting fetch indefinitely.

package mem_bus_arbiter_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Fetch side: 32-bit read-only word accesses.
  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  // Memory-stage side, also the format of the shared memory port.
  typedef struct packed {
    logic        valid;
    addr_t       addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp
);

  // The starvation counter is only 3 bits wide, so the limit must fit in it
  // and a limit of zero would lock data out entirely.
  generate
    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
      $error("mem_bus_arbiter: STARVE_LIMIT must lie in 1..7");
    end
  endgenerate

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] starve_cnt;

  logic starved;
  logic win_i;
  logic win_d;
  logic own_i;
  logic own_d;

  // A fetch is widened onto the memory port as a 4-byte read.
  function automatic dbus_req_t fetch_to_mem(input ibus_req_t r);
    dbus_req_t m;
    m       = '0;
    m.valid = r.valid;
    m.addr  = r.addr;
    m.size  = MSIZE4;
    return m;
  endfunction

  // Arbitration decision for a fresh transaction: data first unless the fetch
  // has waited through STARVE_LIMIT consecutive data grants.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    starved = (starve_cnt == LIMIT);
    win_d   = 1'b0;
    win_i   = 1'b0;
    if (dreq.valid && !(ireq.valid && starved)) begin
      win_d = 1'b1;
    end else if (ireq.valid) begin
      win_i = 1'b1;
    end
  end

  // Current owner of the memory port: the fresh winner in IDLE, otherwise the
  // requester whose transaction is in flight.
  always_comb begin
    own_i = 1'b0;
    own_d = 1'b0;
    case (state)
      IDLE: begin
        own_i = win_i;
        own_d = win_d;
      end
      BUSY_I:  own_i = 1'b1;
      BUSY_D:  own_d = 1'b1;
      default: ;
    endcase
  end

  // Port muxing and response routing; everything is held at zero during reset
  // so nothing leaks onto either bus before the first edge.
  always_comb begin
    mreq  = '0;
    iresp = '0;
    dresp = '0;
    if (reset) begin
      // An owner that dropped valid mid-transaction is still forwarded as-is.
      if (own_d) begin
        mreq = dreq;
      end else if (own_i) begin
        mreq = fetch_to_mem(ireq);
      end

      iresp.addr_ok = own_i & mresp.addr_ok;
      iresp.data_ok = own_i & mresp.data_ok;
      iresp.data    = ireq.addr[2] ? mresp.data[63:32] : mresp.data[31:0];

      dresp.addr_ok = own_d & mresp.addr_ok;
      dresp.data_ok = own_d & mresp.data_ok;
      dresp.data    = mresp.data;
    end
  end

  // Grant FSM and starvation counter. A grant whose data_ok arrives in the
  // same cycle completes without leaving IDLE; otherwise the grant is held
  // until data_ok and the next transaction re-arbitrates in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_d) begin
            if (ireq.valid) begin
              starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 3'd1;
            end else begin
              starve_cnt <= '0;
            end
            if (!mresp.data_ok) state <= BUSY_D;
          end else if (win_i) begin
            starve_cnt <= '0;
            if (!mresp.data_ok) state <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mresp.data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. A simple memory model answers the shared
// port with a programmable latency; each stimulus step queues the transaction
// completions it expects and a monitor compares them as they appear.

module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_i;
    logic [31:0] addr;
    msize_t      size;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  // Expected grant order with both requesters always valid and limit 4.
  bit grant_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .mreq  (mreq),
    .mresp (mresp)
  );

  always #5 clk = ~clk;

  // Memory model: answers addr_ok and data_ok together mem_lat cycles after a
  // request first appears; keeps counting if the requester drops valid.
  int          mem_lat  = 2;
  logic [63:0] mem_data = '0;
  logic [1:0]  wait_cnt;
  logic        mem_active;
  logic        mem_ok;

  assign mem_active = mreq.valid || (wait_cnt != 2'd0);
  assign mem_ok     = mem_active && (int'(wait_cnt) == mem_lat);

  always_comb begin
    mresp         = '0;
    mresp.addr_ok = mem_ok;
    mresp.data_ok = mem_ok;
    mresp.data    = mem_ok ? mem_data : 64'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          wait_cnt <= '0;
    else if (mem_ok)     wait_cnt <= '0;
    else if (mem_active) wait_cnt <= wait_cnt + 2'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input bit is_i, input logic [31:0] addr, input msize_t size,
                            input logic [63:0] data);
    exp_t e;
    e.is_i = is_i;
    e.addr = addr;
    e.size = size;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the owner's data_ok; on every cycle before it the other side
  // must see no addr_ok and the port must keep carrying the owner's address.
  task automatic wait_owner(input bit want_i, input logic [31:0] own_addr, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (want_i ? iresp.data_ok : dresp.data_ok) begin
        done = 1'b1;
      end else begin
        check("peer_addr_ok_quiet", 64'(want_i ? dresp.addr_ok : iresp.addr_ok), 64'd0);
        check("held_addr", 64'(mreq.addr), 64'(own_addr));
      end
    end
    check("owner_done_in_budget", 64'(done), 64'd1);
  endtask

  task automatic wait_completions(input int n, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (iresp.data_ok || dresp.data_ok) got++;
    end
    check("completion_count", 64'(got), 64'(n));
  endtask

  // Monitor: every completion seen on either bus is matched against the next
  // expected transaction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1 && (iresp.data_ok || dresp.data_ok)) begin
      check("completion_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("owner_data_ok", 64'(e.is_i ? iresp.data_ok : dresp.data_ok), 64'd1);
        check("owner_addr_ok", 64'(e.is_i ? iresp.addr_ok : dresp.addr_ok), 64'd1);
        check("other_side_quiet",
              64'(e.is_i ? {dresp.addr_ok, dresp.data_ok} : {iresp.addr_ok, iresp.data_ok}),
              64'd0);
        check("mreq_addr", 64'(mreq.addr), 64'(e.addr));
        check("mreq_size", 64'(mreq.size), 64'(e.size));
        check("resp_data", e.is_i ? {32'h0, iresp.data} : dresp.data, e.data);
      end
    end
  end

  initial begin
    // Reset with both requesters asserting: nothing may reach any output.
    reset = 1'b0;
    ireq  = '0;
    dreq  = '0;
    ireq.valid = 1'b1;
    ireq.addr  = 32'h40;
    dreq.valid = 1'b1;
    dreq.addr  = 32'h80;
    #12;
    check("rst_mreq_zero",  64'(mreq == '0), 64'd1);
    check("rst_iresp_zero", 64'(iresp == '0), 64'd1);
    check("rst_dresp_zero", 64'(dresp == '0), 64'd1);
    ireq = '0;
    dreq = '0;
    step();
    reset = 1'b1;
    step();

    // Fetch only, 2-cycle memory, upper word selected by addr[2].
    mem_lat  = 2;
    mem_data = 64'h1111_2222_3333_4444;
    expect_txn(1'b1, 32'h8000_0004, MSIZE4, 64'h0000_0000_1111_2222);
    step();
    ireq.valid = 1'b1;
    ireq.addr  = 32'h8000_0004;
    @(negedge clk);
    check("t1_mreq_valid",  64'(mreq.valid), 64'd1);
    check("t1_mreq_size",   64'(mreq.size), 64'(MSIZE4));
    check("t1_mreq_strobe", 64'(mreq.strobe), 64'd0);
    check("t1_mreq_data",   mreq.data, 64'd0);
    check("t1_dresp_zero",  64'(dresp == '0), 64'd1);
    wait_owner(1'b1, 32'h8000_0004, 6);
    check("t1_dresp_ok_zero", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    step();
    ireq = '0;

    // Simultaneous requests with an empty counter: data first, fetch next.
    mem_data = 64'hAAAA_BBBB_CCCC_DDDD;
    expect_txn(1'b0, 32'h200, MSIZE8, 64'hAAAA_BBBB_CCCC_DDDD);
    expect_txn(1'b1, 32'h100, MSIZE4, 64'h0000_0000_CCCC_DDDD);
    step();
    ireq.valid  = 1'b1;
    ireq.addr   = 32'h100;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h200;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h5555_6666_7777_8888;
    wait_owner(1'b0, 32'h200, 6);
    step();
    dreq.valid = 1'b0;
    @(negedge clk);
    check("t2_i_granted_valid", 64'(mreq.valid), 64'd1);
    check("t2_i_granted_addr",  64'(mreq.addr), 64'h100);
    wait_owner(1'b1, 32'h100, 6);
    step();
    ireq = '0;
    dreq = '0;

    // Both always valid: starvation guard lets one fetch through every 4 data.
    mem_data = 64'h0F0F_0F0F_F0F0_F0F0;
    for (int k = 0; k < 10; k++) begin
      if (grant_order[k]) expect_txn(1'b1, 32'h300, MSIZE4, 64'h0000_0000_F0F0_F0F0);
      else                expect_txn(1'b0, 32'h400, MSIZE2, 64'h0F0F_0F0F_F0F0_F0F0);
    end
    step();
    ireq.valid = 1'b1;
    ireq.addr  = 32'h300;
    dreq.valid = 1'b1;
    dreq.addr  = 32'h400;
    dreq.size  = MSIZE2;
    wait_completions(10, 60);
    step();
    ireq = '0;
    dreq = '0;
    check("t3_sb_drained", 64'(sb.size()), 64'd0);

    // Zero-latency memory: one data transaction completes every cycle.
    mem_lat  = 0;
    mem_data = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 4; k++) expect_txn(1'b0, 32'h500, MSIZE8, 64'h0123_4567_89AB_CDEF);
    step();
    dreq.valid = 1'b1;
    dreq.addr  = 32'h500;
    dreq.size  = MSIZE8;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_data_ok_pulse", 64'(dresp.data_ok), 64'd1);
    end
    step();
    dreq = '0;
    @(negedge clk);
    check("t4_quiet_after", 64'(dresp.data_ok), 64'd0);

    // Data drops valid mid-transaction: grant held, fetch kept off the port.
    mem_lat  = 2;
    mem_data = 64'h1357_9BDF_2468_ACE0;
    expect_txn(1'b0, 32'h600, MSIZE8, 64'h1357_9BDF_2468_ACE0);
    expect_txn(1'b1, 32'h704, MSIZE4, 64'h0000_0000_1357_9BDF);
    step();
    dreq.valid = 1'b1;
    dreq.addr  = 32'h600;
    dreq.size  = MSIZE8;
    ireq.valid = 1'b1;
    ireq.addr  = 32'h704;
    @(negedge clk);
    check("t5_d_first", 64'(mreq.addr), 64'h600);
    step();
    dreq.valid = 1'b0;
    @(negedge clk);
    check("t5_dropped_valid_seen", 64'(mreq.valid), 64'd0);
    check("t5_i_not_forwarded",    64'(mreq.addr), 64'h600);
    check("t5_iresp_addr_ok",      64'(iresp.addr_ok), 64'd0);
    wait_owner(1'b0, 32'h600, 6);
    step();
    @(negedge clk);
    check("t5_i_after_data_ok", 64'(mreq.addr), 64'h704);
    wait_owner(1'b1, 32'h704, 6);
    step();
    ireq = '0;
    dreq = '0;

    // Reset in the middle of a data transaction, away from any clock edge.
    mem_data = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    dreq.valid = 1'b1;
    dreq.addr  = 32'h800;
    dreq.size  = MSIZE8;
    @(posedge clk);
    #3;
    check("t6_busy_before_reset", 64'(mreq.addr), 64'h800);
    reset = 1'b0;
    #1;
    check("t6_mreq_zero",  64'(mreq == '0), 64'd1);
    check("t6_iresp_zero", 64'(iresp == '0), 64'd1);
    check("t6_dresp_zero", 64'(dresp == '0), 64'd1);
    dreq = '0;
    ireq.valid = 1'b1;
    ireq.addr  = 32'h904;
    expect_txn(1'b1, 32'h904, MSIZE4, 64'h0000_0000_DEAD_BEEF);
    @(posedge clk);
    #3;
    check("t6_held_in_reset", 64'(mreq == '0), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_first_grant_valid", 64'(mreq.valid), 64'd1);
    check("t6_first_grant_addr",  64'(mreq.addr), 64'h904);
    wait_owner(1'b1, 32'h904, 6);
    step();
    ireq = '0;

    // Every queued completion must have been observed.
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants issued while an instruction request waits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ireq  input  ibus_req_t  fetch-side request.
REQ-005 SHALL have port iresp  output  ibus_resp_t  fetch-side response.
REQ-006 SHALL have port dreq  input  dbus_req_t  memory-stage request.
REQ-007 SHALL have port dresp  output  dbus_resp_t  memory-stage response.
REQ-008 SHALL have port mreq  output  dbus_req_t  shared memory-port request.
REQ-009 SHALL have port mresp  input  dbus_resp_t  shared memory-port response.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, encoded in 2 bits.
REQ-011 SHALL, in IDLE, select a winner combinationally, with no added cycle: dreq.valid wins unless both valid and starve_cnt == STARVE_LIMIT, in which case ireq wins; otherwise the sole valid requester wins.
REQ-012 SHALL, in IDLE with no valid requester, drive mreq = '0.
REQ-013 SHALL drive mreq from the winner: dreq unchanged; ireq as {valid, addr, MSIZE4, strobe 8'b0, data 64'b0}.
REQ-014 SHALL, in IDLE with a winner, move to BUSY_I or BUSY_D at the next edge unless mresp.data_ok is 1 in the same cycle, in which case it stays IDLE.
REQ-015 SHALL, in BUSY_x, drive mreq from requester x only, ignore the other requester, and return to IDLE on the edge where mresp.data_ok = 1.
REQ-016 SHALL hold the grant until data_ok even if the owning requester drops valid; mreq then reflects that requester's current (dropped) inputs.
REQ-017 SHALL route mresp.addr_ok and mresp.data_ok only to the current owner; the non-owner sees addr_ok = data_ok = 0.
REQ-018 SHALL drive iresp.data = mresp.data[63:32] when ireq.addr[2] = 1, else mresp.data[31:0]; dresp.data = mresp.data.
REQ-019 SHALL keep a 3-bit starve_cnt: on a data grant in IDLE with ireq.valid = 1, increment, saturating at STARVE_LIMIT; on a data grant with ireq.valid = 0, clear to 0; on any instruction grant, clear to 0.
REQ-020 SHALL give each transaction one cycle of arbitration: back-to-back transactions from the same requester re-arbitrate in IDLE after every data_ok.

Reset
REQ-021 SHALL, while reset = 0, force state IDLE, starve_cnt = 0, mreq = '0, iresp = '0 and dresp = '0, independent of clk.
REQ-022 SHALL, on reset assertion during BUSY_x, abandon the in-flight transaction and take the first arbitration decision after release from current inputs.
REQ-023 SHALL require STARVE_LIMIT to lie in 1..7; other values are a compile-time error.

Verification
REQ-024 Bench SHALL cover: ireq only, addr 0x8000_0004, memory returns 0x1111_2222_3333_4444 with addr_ok and data_ok 2 cycles later -> mreq.size = MSIZE4, iresp.data = 0x1111_2222, dresp all 0.
REQ-025 Bench SHALL cover: ireq and dreq valid in the same cycle, starve_cnt = 0 -> dreq granted; iresp.addr_ok stays 0 until the data transaction's data_ok, then ireq is granted next cycle.
REQ-026 Bench SHALL cover: dreq and ireq continuously valid, STARVE_LIMIT = 4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-027 Bench SHALL cover: memory returns addr_ok and data_ok in the same cycle as request -> FSM stays IDLE, one transaction per cycle, dresp.data_ok pulses each cycle.
REQ-028 Bench SHALL cover: reset driven low mid BUSY_D, away from any clk edge -> mreq, iresp and dresp go 0 immediately; after release with only ireq valid -> ireq is granted on the first cycle.
REQ-029 Bench SHALL cover: dreq drops valid while in BUSY_D, ireq valid -> grant stays D until mresp.data_ok, and ireq is not forwarded before then.
